// File: rtl/kernel_jacobi_2d_mul_pipe.sv
// kernel_jacobi_2d_mul_pipe
//   Pipelined integer multiplier with valid/ready handshake, clock enable and
//   global stall. Operands are captured in stage 0, the full product is formed
//   between stage 0 and stage 1, and the remaining stages only retime the
//   result. With NUM_STAGE=1 the product is registered directly from the inputs.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   ce        : clock enable; 0 freezes every register and forces in_ready=0
//   in_valid  : operand pair valid
//   in_ready  : operand pair accepted this cycle when in_valid is also high
//   din0/din1 : operands a (din0_WIDTH) and b (din1_WIDTH)
//   out_valid : dout holds a valid result
//   out_ready : consumer takes dout this cycle
//   dout      : product, truncated or extended to dout_WIDTH
module kernel_jacobi_2d_mul_pipe #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned NUM_STAGE  = 32'd3,
  parameter int unsigned din0_WIDTH = 32'd10,
  parameter int unsigned din1_WIDTH = 32'd11,
  parameter int unsigned dout_WIDTH = 32'd20,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int unsigned PW = din0_WIDTH + din1_WIDTH;
  localparam int unsigned EW = (dout_WIDTH > PW) ? dout_WIDTH : PW;

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
    $error("kernel_jacobi_2d_mul_pipe ID %0d: NUM_STAGE=%0d outside 1..8", ID, NUM_STAGE);
  end

  // Both operands are extended to the full product width so a single
  // PW x PW multiply (kept to PW bits) yields the exact signed or unsigned
  // product; the result is then extended to EW and cut to dout_WIDTH, which
  // covers both wrap-around truncation and zero/sign extension.
  function automatic logic [dout_WIDTH-1:0] mul_fit(input logic [din0_WIDTH-1:0] a,
                                                    input logic [din1_WIDTH-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    logic [PW-1:0] p;
    logic [EW-1:0] pe;
    ax = {{din1_WIDTH{SIGNED & a[din0_WIDTH-1]}}, a};
    bx = {{din0_WIDTH{SIGNED & b[din1_WIDTH-1]}}, b};
    p  = ax * bx;
    pe = {EW{SIGNED & p[PW-1]}};
    pe[PW-1:0] = p;
    return pe[dout_WIDTH-1:0];
  endfunction

  logic                 adv;
  logic [NUM_STAGE-1:0] vld_q;
  logic [NUM_STAGE-1:0] vld_d;

  // One global advance: the whole pipe shifts only when the output slot is
  // free or being drained, so bubbles stay in place and are never collapsed.
  assign adv       = ce & (~vld_q[NUM_STAGE-1] | out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_q[NUM_STAGE-1];

  always_comb begin
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = in_valid;
      for (int unsigned i = 1; i < NUM_STAGE; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Data registers load only alongside a valid bit, so from reset until the
  // first result the output data stays at zero.
  if (NUM_STAGE == 1) begin : g_single
    logic [dout_WIDTH-1:0] res_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                 res_q <= '0;
      else if (adv && in_valid)  res_q <= mul_fit(din0, din1);
    end

    assign dout = res_q;
  end else begin : g_multi
    logic [din0_WIDTH-1:0] a_q;
    logic [din1_WIDTH-1:0] b_q;
    logic [dout_WIDTH-1:0] res_q [1:NUM_STAGE-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
        for (int unsigned i = 1; i < NUM_STAGE; i++) begin
          res_q[i] <= '0;
        end
      end else if (adv) begin
        if (in_valid) begin
          a_q <= din0;
          b_q <= din1;
        end
        if (vld_q[0]) res_q[1] <= mul_fit(a_q, b_q);
        for (int unsigned i = 2; i < NUM_STAGE; i++) begin
          if (vld_q[i-1]) res_q[i] <= res_q[i-1];
        end
      end
    end

    assign dout = res_q[NUM_STAGE-1];
  end

endmodule

// File: tb/tb_kernel_jacobi_2d_mul_pipe.sv
module tb_kernel_jacobi_2d_mul_pipe;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic [9:0]  din0;
  logic [10:0] din1;
  logic        out_ready;
  logic        in_ready_u, in_ready_s;
  logic        out_valid_u, out_valid_s;
  logic [19:0] dout_u, dout_s;

  kernel_jacobi_2d_mul_pipe #(
    .ID(1), .NUM_STAGE(3), .din0_WIDTH(10), .din1_WIDTH(11), .dout_WIDTH(20), .SIGNED(1'b0)
  ) u_dut_u (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_u),
    .din0(din0), .din1(din1), .out_valid(out_valid_u), .out_ready(out_ready), .dout(dout_u)
  );

  kernel_jacobi_2d_mul_pipe #(
    .ID(2), .NUM_STAGE(3), .din0_WIDTH(10), .din1_WIDTH(11), .dout_WIDTH(20), .SIGNED(1'b1)
  ) u_dut_s (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_s),
    .din0(din0), .din1(din1), .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s)
  );

  typedef struct packed {
    logic [19:0] u;
    logic [19:0] s;
  } exp_t;

  typedef struct {
    logic [9:0]  a;
    logic [10:0] b;
    logic [19:0] eu;
    logic [19:0] es;
  } vec_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          tests = 0;
  int          fails = 0;
  int          retired = 0;
  logic        hold_prev = 1'b0;
  logic [19:0] held_u, held_s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples mid-cycle the handshakes that the next rising
  // edge will complete.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, out_valid_u}, 32'd1);
        chk("hold_dout_u", {12'd0, dout_u}, {12'd0, held_u});
        chk("hold_dout_s", {12'd0, dout_s}, {12'd0, held_s});
      end
      if (out_valid_u && !out_ready) chk("stall_in_ready", {31'd0, in_ready_u}, 32'd0);
      if (!ce) chk("ce_in_ready", {31'd0, in_ready_u | in_ready_s}, 32'd0);
      if (out_valid_u && out_ready && ce) begin
        retired++;
        if (sb.size() == 0) begin
          chk("unexpected_result", {12'd0, dout_u}, 32'hFFFFFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dout_u", {12'd0, dout_u}, {12'd0, e.u});
          chk("dout_s", {12'd0, dout_s}, {12'd0, e.s});
          chk("out_valid_s", {31'd0, out_valid_s}, 32'd1);
        end
      end
      if (in_valid && in_ready_u && ce) sb.push_back(cur_exp);
      hold_prev = out_valid_u & ~(out_ready & ce);
      held_u    = dout_u;
      held_s    = dout_s;
    end
  end

  // Present one operand pair from posedge+1 and return at posedge+1 after
  // the edge that accepted it (in_valid is left high for back-to-back use).
  task automatic send(input logic [9:0] a, input logic [10:0] b,
                      input logic [19:0] eu, input logic [19:0] es);
    logic acc;
    acc       = 1'b0;
    in_valid  = 1'b1;
    din0      = a;
    din1      = b;
    cur_exp.u = eu;
    cur_exp.s = es;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready_u & ce;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Counts falling edges after the accepting edge until out_valid is seen.
  task automatic measure(input int start, output int n);
    n = start;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid_u) break;
    end
  endtask

  vec_t vt [9];
  int   lat;
  int   base;
  logic stale;

  initial begin
    vt[0] = '{10'd5,     11'd7,     20'd35,      20'd35};
    vt[1] = '{10'd1023,  11'd2047,  20'd1045505, 20'd1};
    vt[2] = '{10'h3FF,   11'd3,     20'd3069,    20'hFFFFD};
    vt[3] = '{10'h200,   11'h400,   20'd524288,  20'd524288};
    vt[4] = '{10'd0,     11'd2047,  20'd0,       20'd0};
    vt[5] = '{10'd511,   11'd1023,  20'd522753,  20'd522753};
    vt[6] = '{10'h200,   11'd1,     20'd512,     20'hFFE00};
    vt[7] = '{10'd1023,  11'h400,   20'd1047552, 20'd1024};
    vt[8] = '{10'd100,   11'h7F6,   20'd203800,  20'hFFC18};

    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
    cur_exp = '0;
    #2;
    chk("reset_out_valid", {31'd0, out_valid_u | out_valid_s}, 32'd0);
    chk("reset_dout_u", {12'd0, dout_u}, 32'd0);
    chk("reset_dout_s", {12'd0, dout_s}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready_u}, 32'd1);
    ce = 1'b0;
    #1;
    chk("reset_in_ready_ce0", {31'd0, in_ready_u}, 32'd0);
    ce = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Single op: valid exactly 3 cycles after acceptance, for one cycle.
    send(10'd5, 11'd7, 20'd35, 20'd35);
    in_valid = 1'b0;
    measure(0, lat);
    chk("latency", lat, 32'd3);
    @(negedge clk);
    chk("one_cycle_valid", {31'd0, out_valid_u}, 32'd0);
    wait_drain();

    // Vector table streamed back-to-back.
    for (int i = 0; i < 9; i++) send(vt[i].a, vt[i].b, vt[i].eu, vt[i].es);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: 6 pairs, consumer stalls 5 cycles from cycle 4.
    base = retired;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(10'(i), 11'(i + 1), 20'(i * (i + 1)), 20'(i * (i + 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count", retired - base, 32'd6);

    // Clock enable low for 4 cycles right after acceptance.
    send(10'd9, 11'd9, 20'd81, 20'd81);
    in_valid = 1'b0;
    ce = 1'b0;
    lat = 0;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    chk("ce_frozen_valid", {31'd0, out_valid_u}, 32'd0);
    @(posedge clk);
    #1 ce = 1'b1;
    measure(lat, lat);
    chk("ce_latency", lat, 32'd7);
    wait_drain();

    // Asynchronous reset with three results in flight.
    send(10'd3, 11'd4, 20'd12, 20'd12);
    send(10'd6, 11'd7, 20'd42, 20'd42);
    send(10'd8, 11'd9, 20'd72, 20'd72);
    in_valid = 1'b0;
    #2;
    chk("pre_reset_valid", {31'd0, out_valid_u}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid_u | out_valid_s}, 32'd0);
    chk("async_dout_u", {12'd0, dout_u}, 32'd0);
    chk("async_dout_s", {12'd0, dout_s}, 32'd0);
    #4 reset = 1'b0;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_u || out_valid_s || dout_u != '0 || dout_s != '0) stale = 1'b1;
    end
    chk("no_stale_after_reset", {31'd0, stale}, 32'd0);
    @(posedge clk);
    #1;
    send(vt[8].a, vt[8].b, vt[8].eu, vt[8].es);
    in_valid = 1'b0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
